// File: rtl/rf_pkg.sv
// Shared constants and types for the GPR file with scoreboard.
package rf_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NREGS_RV32I = 32;
    localparam int unsigned NREGS_RV32E = 16;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 1;
    localparam int unsigned REG_A0   = 10;

    typedef logic [$clog2(NREGS_RV32I)-1:0] idx_t;
    typedef logic [XLEN_DEF-1:0]            xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: allocate on issue, clear on writeback.
// Honours RF_BYPASS_EN: same-cycle writeback makes the register look free.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_RV32I,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NRD*IDX_W-1:0] i_rd_idx,
    input  logic                 i_iss_valid,
    input  logic [IDX_W-1:0]     i_iss_idx,
    input  logic [NWR-1:0]       i_wb_wen,
    input  logic [NWR*IDX_W-1:0] i_wb_idx,
    output logic [NRD-1:0]       o_rd_busy,
    output logic                 o_iss_ready,
    output logic                 o_sb_idle
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_d;
    logic [NREGS-1:0] w_wb_hit;
    logic [NREGS-1:0] w_busy_vis;
    logic             w_alloc;

    always_comb begin
        w_wb_hit = '0;
        for (int w = 0; w < NWR; w++) begin
            if (i_wb_wen[w]) w_wb_hit[i_wb_idx[w*IDX_W +: IDX_W]] = 1'b1;
        end
        w_wb_hit[0] = 1'b0;
    end

`ifdef RF_BYPASS_EN
    assign w_busy_vis = r_busy & ~w_wb_hit;
`else
    assign w_busy_vis = r_busy;
`endif

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            o_rd_busy[p] = w_busy_vis[i_rd_idx[p*IDX_W +: IDX_W]];
        end
    end

    assign o_iss_ready = (i_iss_idx == '0) | ~w_busy_vis[i_iss_idx];
    assign w_alloc     = i_iss_valid & o_iss_ready & (i_iss_idx != '0);
    assign o_sb_idle   = ~|r_busy;

    // Allocation is applied after the clear so a same-cycle re-allocation wins.
    always_comb begin
        w_busy_d = r_busy & ~w_wb_hit;
        if (w_alloc) w_busy_d[i_iss_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_busy_d;
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with integrated busy-bit scoreboard.
// Optional write-through read bypass enabled by defining RF_BYPASS_EN.
module gpr_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_RV32I,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NRD*IDX_W-1:0] i_rd_idx,
    output logic [NRD*XLEN-1:0]  o_rd_dat,
    output logic [NRD-1:0]       o_rd_busy,
    input  logic                 i_iss_valid,
    input  logic [IDX_W-1:0]     i_iss_idx,
    output logic                 o_iss_ready,
    input  logic [NWR-1:0]       i_wb_wen,
    input  logic [NWR*IDX_W-1:0] i_wb_idx,
    input  logic [NWR*XLEN-1:0]  i_wb_dat,
    output logic [XLEN-1:0]      o_a0_r,
    output logic                 o_sb_idle
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Later ports are assigned last, so the highest port wins on a collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (i_wb_wen[w] && (i_wb_idx[w*IDX_W +: IDX_W] != '0)) begin
                    r_regs[i_wb_idx[w*IDX_W +: IDX_W]] <= i_wb_dat[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            o_rd_dat[p*XLEN +: XLEN] = '0;
            if (i_rd_idx[p*IDX_W +: IDX_W] != '0) begin
                o_rd_dat[p*XLEN +: XLEN] = r_regs[i_rd_idx[p*IDX_W +: IDX_W]];
`ifdef RF_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (i_wb_wen[w] &&
                        (i_wb_idx[w*IDX_W +: IDX_W] == i_rd_idx[p*IDX_W +: IDX_W])) begin
                        o_rd_dat[p*XLEN +: XLEN] = i_wb_dat[w*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    generate
        if (NREGS > REG_A0) begin : g_a0
            assign o_a0_r = r_regs[REG_A0];
        end else begin : g_no_a0
            assign o_a0_r = '0;
        end
    endgenerate

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (i_rd_idx),
        .i_iss_valid (i_iss_valid),
        .i_iss_idx   (i_iss_idx),
        .i_wb_wen    (i_wb_wen),
        .i_wb_idx    (i_wb_idx),
        .o_rd_busy   (o_rd_busy),
        .o_iss_ready (o_iss_ready),
        .o_sb_idle   (o_sb_idle)
    );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb (NWR=2): directed table, corner sequences,
// then random traffic against an array-based reference model.
module tb_gpr_file_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned IDX_W = 5;

    logic                 clk;
    logic                 rst;
    logic [NRD*IDX_W-1:0] rd_idx;
    logic [NRD*XLEN-1:0]  rd_dat;
    logic [NRD-1:0]       rd_busy;
    logic                 iss_valid;
    logic [IDX_W-1:0]     iss_idx;
    logic                 iss_ready;
    logic [NWR-1:0]       wb_wen;
    logic [NWR*IDX_W-1:0] wb_idx;
    logic [NWR*XLEN-1:0]  wb_dat;
    logic [XLEN-1:0]      a0_r;
    logic                 sb_idle;

    int checks;
    int errors;

    gpr_file_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_idx    (rd_idx),
        .o_rd_dat    (rd_dat),
        .o_rd_busy   (rd_busy),
        .i_iss_valid (iss_valid),
        .i_iss_idx   (iss_idx),
        .o_iss_ready (iss_ready),
        .i_wb_wen    (wb_wen),
        .i_wb_idx    (wb_idx),
        .i_wb_dat    (wb_dat),
        .o_a0_r      (a0_r),
        .o_sb_idle   (sb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0] mreg  [NREGS];
    bit              mbusy [NREGS];

    function automatic int wi(input int w);
        return int'(wb_idx[w*IDX_W +: IDX_W]);
    endfunction

    function automatic bit m_byp(input int idx);
        bit hit = 0;
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWR; w++) if (wb_wen[w] && wi(w) == idx && idx != 0) hit = 1;
`endif
        return hit;
    endfunction

    function automatic logic [XLEN-1:0] m_rd(input int idx);
        logic [XLEN-1:0] v = (idx == 0) ? '0 : mreg[idx];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (wb_wen[w] && wi(w) == idx && idx != 0) v = wb_dat[w*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic bit m_ready(input int idx);
        return idx == 0 || !mbusy[idx] || m_byp(idx);
    endfunction

    function automatic bit m_idle();
        for (int i = 0; i < NREGS; i++) if (mbusy[i]) return 0;
        return 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 0;
        end
    endtask

    // Call right after the edge with the inputs that were sampled.
    task automatic m_edge(input bit ready_pre);
        for (int w = 0; w < NWR; w++) begin
            if (wb_wen[w] && wi(w) != 0) begin
                mreg[wi(w)]  = wb_dat[w*XLEN +: XLEN];
                mbusy[wi(w)] = 0;
            end
        end
        if (iss_valid && ready_pre && iss_idx != 0) mbusy[iss_idx] = 1;
    endtask

    task automatic m_check();
        for (int p = 0; p < NRD; p++) begin
            int idx = int'(rd_idx[p*IDX_W +: IDX_W]);
            chk($sformatf("rnd rd_dat%0d x%0d", p, idx), rd_dat[p*XLEN +: XLEN], m_rd(idx));
            chk($sformatf("rnd rd_busy%0d x%0d", p, idx), 32'(rd_busy[p]),
                32'(mbusy[idx] && idx != 0 && !m_byp(idx)));
        end
        chk("rnd iss_ready", 32'(iss_ready), 32'(m_ready(int'(iss_idx))));
        chk("rnd sb_idle", 32'(sb_idle), 32'(m_idle()));
        chk("rnd a0_r", a0_r, mreg[10]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  widx0, widx1;
        logic [31:0] wdat0, wdat1;
        logic        ivalid;
        logic [4:0]  iidx;
        logic [4:0]  cidx;
        logic [31:0] e_dat;
        logic        e_busy, e_ready, e_idle;
        logic [31:0] e_a0;
    } vec_t;

    vec_t vecs [7];

    task automatic idle_inputs();
        wb_wen    = '0;
        wb_idx    = '0;
        wb_dat    = '0;
        iss_valid = 1'b0;
        iss_idx   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_reset();
        vecs[0] = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd0,
                    5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[1] = '{2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 1'b0, 5'd0,
                    5'd7, 32'h2222, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[2] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3,
                    5'd3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{2'b01, 5'd3, 5'd0, 32'h42, 32'h0, 1'b0, 5'd0,
                    5'd3, 32'h42, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{2'b10, 5'd0, 5'd4, 32'h0, 32'h99, 1'b1, 5'd4,
                    5'd4, 32'h99, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{2'b01, 5'd4, 5'd0, 32'h5, 32'h0, 1'b0, 5'd0,
                    5'd4, 32'h5, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[6] = '{2'b10, 5'd0, 5'd10, 32'h0, 32'h1234_5678, 1'b0, 5'd0,
                    5'd10, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h1234_5678};

        rst = 1'b1;
        idle_inputs();
        rd_idx = {5'd10, 5'd5};
        #12;
        chk("reset rd_dat0", rd_dat[31:0], 32'h0);
        chk("reset rd_busy", 32'(rd_busy), 32'h0);
        chk("reset iss_ready", 32'(iss_ready), 32'h1);
        chk("reset sb_idle", 32'(sb_idle), 32'h1);
        chk("reset a0_r", a0_r, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            wb_wen    = vecs[i].wen;
            wb_idx    = {vecs[i].widx1, vecs[i].widx0};
            wb_dat    = {vecs[i].wdat1, vecs[i].wdat0};
            iss_valid = vecs[i].ivalid;
            iss_idx   = vecs[i].iidx;
            @(posedge clk);
            #1;
            idle_inputs();
            rd_idx  = {5'd0, vecs[i].cidx};
            iss_idx = vecs[i].cidx;
            #1;
            chk($sformatf("vec%0d rd_dat", i), rd_dat[31:0], vecs[i].e_dat);
            chk($sformatf("vec%0d rd_busy", i), 32'(rd_busy[0]), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d iss_ready", i), 32'(iss_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d sb_idle", i), 32'(sb_idle), 32'(vecs[i].e_idle));
            chk($sformatf("vec%0d a0_r", i), a0_r, vecs[i].e_a0);
        end

        // Writeback x10=0 while reading it: bypass-dependent same-cycle view.
        wb_wen = 2'b01;
        wb_idx = {5'd0, 5'd10};
        wb_dat = '0;
        rd_idx = {5'd0, 5'd10};
        #1;
`ifdef RF_BYPASS_EN
        chk("a0 wb same-cycle rd_dat", rd_dat[31:0], 32'h0);
`else
        chk("a0 wb same-cycle rd_dat", rd_dat[31:0], 32'h1234_5678);
`endif
        chk("a0 wb same-cycle a0_r", a0_r, 32'h1234_5678);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("a0 wb next rd_dat", rd_dat[31:0], 32'h0);
        chk("a0 wb next a0_r", a0_r, 32'h0);

        // Reset asserted between edges clears state immediately.
        wb_wen    = 2'b11;
        wb_idx    = {5'd10, 5'd5};
        wb_dat    = {32'h7, 32'hDEAD_BEEF};
        iss_valid = 1'b1;
        iss_idx   = 5'd6;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_idx = {5'd6, 5'd5};
        #1;
        chk("pre-rst rd_dat x5", rd_dat[31:0], 32'hDEAD_BEEF);
        chk("pre-rst rd_busy x6", 32'(rd_busy[1]), 32'h1);
        chk("pre-rst a0_r", a0_r, 32'h7);
        rst = 1'b1;
        #1;
        chk("mid-rst rd_dat x5", rd_dat[31:0], 32'h0);
        chk("mid-rst rd_busy x6", 32'(rd_busy[1]), 32'h0);
        chk("mid-rst sb_idle", 32'(sb_idle), 32'h1);
        chk("mid-rst a0_r", a0_r, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;

        // Random traffic; indices biased low to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            bit rdy;
            for (int w = 0; w < NWR; w++) begin
                wb_wen[w] = ($urandom_range(0, 2) == 0);
                wb_idx[w*IDX_W +: IDX_W] = 5'(($urandom_range(0, 1) != 0) ?
                                              $urandom_range(0, 7) : $urandom_range(0, 31));
                wb_dat[w*XLEN +: XLEN] = $urandom;
            end
            for (int p = 0; p < NRD; p++)
                rd_idx[p*IDX_W +: IDX_W] = 5'(($urandom_range(0, 1) != 0) ?
                                              $urandom_range(0, 7) : $urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_idx   = 5'($urandom_range(0, 7));
            @(negedge clk);
            m_check();
            rdy = m_ready(int'(iss_idx));
            @(posedge clk);
            m_edge(rdy);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
